cdb_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the single common result bus shared by all functional units (adders, multipliers, loaders, storers).
- Picks one completing FU per cycle and registers its payload (data, store address, reorder-buffer index) onto the bus.
- Acknowledges the winning FU and holds the broadcast while the reorder buffer back-pressures.
- Sits between the FU result ports and the reorder buffer / reservation-station snoop logic.

---
 rtl/cdb_arbiter_pkg.sv | 28 ++
 rtl/cdb_arbiter_rr_pick.sv | 36 +++
 rtl/cdb_arbiter.sv | 163 ++++++++++++++++
 tb/tb_cdb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common-data-bus arbiter: FU index map, bus widths
// and the broadcast state encoding.
package cdb_arbiter_pkg;

    // Functional-unit index map on the request vector
    localparam int ADDER_START  = 32'd0;
    localparam int ADDER_NUM    = 32'd2;
    localparam int MULTER_START = 32'd2;
    localparam int MULTER_NUM   = 32'd2;
    localparam int LOADER_START = 32'd4;
    localparam int LOADER_NUM   = 32'd2;
    localparam int STORER_START = 32'd6;
    localparam int STORER_NUM   = 32'd2;

    localparam int FU_COUNT  = ADDER_NUM + MULTER_NUM + LOADER_NUM + STORER_NUM;
    // Sentinel index meaning "no functional unit"
    localparam int NO_FU     = FU_COUNT;

    localparam int WORD_SIZE = 32'd32;
    localparam int RB_INDEX  = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        HOLD  = 2'd2
    } cdb_state_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational round-robin picker: the first eligible requester strictly after
// rr_ptr (wrapping) wins; rr_ptr itself has the lowest priority.
module cdb_arbiter_rr_pick #(
    parameter int N  = 8,
    parameter int IW = 3
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  winner_oh,
    output logic [IW-1:0] winner_idx,
    output logic          found
);

    // Scan N slots starting after rr_ptr and keep the first eligible hit.
    always_comb begin
        int          cand_s;
        logic [IW-1:0] cand_idx_s;
        winner_oh  = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand_s     = 0;
        cand_idx_s = '0;
        for (int k = 1; k <= N; k++) begin
            cand_s     = (int'(rr_ptr) + k) % N;
            cand_idx_s = cand_s[IW-1:0];
            if (!found && eligible[cand_idx_s]) begin
                found                 = 1'b1;
                winner_oh[cand_idx_s] = 1'b1;
                winner_idx            = cand_idx_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the shared result bus. One completing FU per cycle is
// granted and its payload registered onto cdb_*; the broadcast is held while the
// ROB back-pressures. Optional counters: define CDB_STATS_EN.
module cdb_arbiter #(
    parameter  int FU_NUM    = cdb_arbiter_pkg::FU_COUNT,
    parameter  int WORD_SIZE = cdb_arbiter_pkg::WORD_SIZE,
    parameter  int RB_INDEX  = cdb_arbiter_pkg::RB_INDEX,
    localparam int FU_IDX    = $clog2(FU_NUM)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic [FU_NUM-1:0]             req,
    input  logic [FU_NUM*WORD_SIZE-1:0]   req_data,
    input  logic [FU_NUM*WORD_SIZE-1:0]   req_addr,
    input  logic [FU_NUM*RB_INDEX-1:0]    req_rbidx,
    output logic [FU_NUM-1:0]             gnt,
    output logic                          cdb_valid,
    output logic [WORD_SIZE-1:0]          cdb_data,
    output logic [WORD_SIZE-1:0]          cdb_addr,
    output logic [RB_INDEX-1:0]           cdb_rbidx,
    output logic [FU_IDX-1:0]             cdb_fu,
`ifdef CDB_STATS_EN
    output logic [31:0]                   stat_bcast,
    output logic [31:0]                   stat_stall,
`endif
    input  logic                          cdb_ready
);

    import cdb_arbiter_pkg::*;

    cdb_state_e            state_q, state_d;
    logic [FU_IDX-1:0]     rr_ptr_q, rr_ptr_d;
    logic [FU_NUM-1:0]     gnt_q, gnt_d;
    logic                  valid_q, valid_d;
    logic [WORD_SIZE-1:0]  data_q, data_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [RB_INDEX-1:0]   rbidx_q, rbidx_d;
    logic [FU_IDX-1:0]     fu_q, fu_d;

    logic [FU_NUM-1:0]     eligible_s;
    logic [FU_NUM-1:0]     win_oh_s;
    logic [FU_IDX-1:0]     win_idx_s;
    logic                  found_s;
    logic                  arb_en_s;

    // A unit granted last cycle still shows req this cycle; keep it out.
    assign eligible_s = req & ~gnt_q;

    cdb_arbiter_rr_pick #(
        .N  (FU_NUM),
        .IW (FU_IDX)
    ) u_rr_pick (
        .eligible   (eligible_s),
        .rr_ptr     (rr_ptr_q),
        .winner_oh  (win_oh_s),
        .winner_idx (win_idx_s),
        .found      (found_s)
    );

    // Next-state and next-output logic: flush, then stall, then arbitration.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = '0;
        valid_d  = valid_q;
        data_d   = data_q;
        addr_d   = addr_q;
        rbidx_d  = rbidx_q;
        fu_d     = fu_q;

        case (state_q)
            IDLE:        arb_en_s = 1'b1;
            BCAST, HOLD: arb_en_s = cdb_ready;
            default:     arb_en_s = 1'b1;
        endcase

        if (flush) begin
            state_d = IDLE;
            valid_d = 1'b0;
        end else if (!arb_en_s) begin
            state_d = HOLD;
        end else if (found_s) begin
            state_d  = BCAST;
            valid_d  = 1'b1;
            gnt_d    = win_oh_s;
            rr_ptr_d = win_idx_s;
            fu_d     = win_idx_s;
            data_d   = req_data[int'(win_idx_s) * WORD_SIZE +: WORD_SIZE];
            addr_d   = req_addr[int'(win_idx_s) * WORD_SIZE +: WORD_SIZE];
            rbidx_d  = req_rbidx[int'(win_idx_s) * RB_INDEX +: RB_INDEX];
        end else begin
            state_d = IDLE;
            valid_d = 1'b0;
        end
    end

    // State, pointer and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= FU_IDX'(FU_NUM - 1);
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            addr_q   <= '0;
            rbidx_q  <= '0;
            fu_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            addr_q   <= addr_d;
            rbidx_q  <= rbidx_d;
            fu_q     <= fu_d;
        end
    end

    assign gnt       = gnt_q;
    assign cdb_valid = valid_q;
    assign cdb_data  = data_q;
    assign cdb_addr  = addr_q;
    assign cdb_rbidx = rbidx_q;
    assign cdb_fu    = fu_q;

`ifdef CDB_STATS_EN
    logic [31:0] stat_bcast_q, stat_bcast_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating counts of broadcasts started and of stalled cycles.
    always_comb begin
        stat_bcast_d = stat_bcast_q;
        stat_stall_d = stat_stall_q;
        if ((state_d == BCAST) && (stat_bcast_q != 32'hFFFF_FFFF)) begin
            stat_bcast_d = stat_bcast_q + 32'd1;
        end else begin
            stat_bcast_d = stat_bcast_q;
        end
        if ((state_d == HOLD) && (stat_stall_q != 32'hFFFF_FFFF)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Counter registers; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_bcast_q <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            stat_bcast_q <= stat_bcast_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_bcast = stat_bcast_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios followed by randomized traffic,
// all checked against a queue-based reference model of the bus protocol.
module tb_cdb_arbiter;

    localparam int N = 8;
    localparam int W = 32;
    localparam int R = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             cdb_ready;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N*W-1:0]   req_addr;
    logic [N*R-1:0]   req_rbidx;
    logic [N-1:0]     gnt;
    logic             cdb_valid;
    logic [W-1:0]     cdb_data;
    logic [W-1:0]     cdb_addr;
    logic [R-1:0]     cdb_rbidx;
    logic [2:0]       cdb_fu;
`ifdef CDB_STATS_EN
    logic [31:0]      stat_bcast;
    logic [31:0]      stat_stall;
`endif

    cdb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req       (req),
        .req_data  (req_data),
        .req_addr  (req_addr),
        .req_rbidx (req_rbidx),
        .gnt       (gnt),
        .cdb_valid (cdb_valid),
        .cdb_data  (cdb_data),
        .cdb_addr  (cdb_addr),
        .cdb_rbidx (cdb_rbidx),
        .cdb_fu    (cdb_fu),
`ifdef CDB_STATS_EN
        .stat_bcast(stat_bcast),
        .stat_stall(stat_stall),
`endif
        .cdb_ready (cdb_ready)
    );

    always #5 clk = ~clk;

    // Functional-unit side of the handshake
    logic         fu_req  [N];
    logic [W-1:0] fu_data [N];
    logic [W-1:0] fu_addr [N];
    logic [R-1:0] fu_rb   [N];
    bit           auto_drop;

    // Reference model state
    bit           m_valid;
    int           m_ptr;
    logic [N-1:0] m_gnt;
    logic [W-1:0] m_data;
    logic [W-1:0] m_addr;
    logic [R-1:0] m_rb;
    int           m_fu;
    int           m_nb;
    int           m_ns;

    int nvec;
    int nfail;
    int cnt [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]               = fu_req[i];
            req_data[i*W +: W]   = fu_data[i];
            req_addr[i*W +: W]   = fu_addr[i];
            req_rbidx[i*R +: R]  = fu_rb[i];
        end
    endtask

    // Round-robin choice: lowest eligible index above ptr, else lowest overall.
    function automatic int pick(input logic [N-1:0] elig, input int ptr);
        int above[$];
        int any[$];
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                any.push_back(i);
                if (i > ptr) above.push_back(i);
            end
        end
        if (above.size() > 0) return above[0];
        if (any.size() > 0) return any[0];
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        if (flush) begin
            m_valid = 1'b0;
            m_gnt   = '0;
        end else if (m_valid && !cdb_ready) begin
            m_gnt = '0;
            m_ns++;
        end else begin
            w = pick(req & ~m_gnt, m_ptr);
            m_gnt = '0;
            if (w >= 0) begin
                m_gnt[w] = 1'b1;
                m_data   = fu_data[w];
                m_addr   = fu_addr[w];
                m_rb     = fu_rb[w];
                m_fu     = w;
                m_ptr    = w;
                m_valid  = 1'b1;
                m_nb++;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic fl, input logic rdy);
        flush     = fl;
        cdb_ready = rdy;
        drive();
        model_edge();
        @(posedge clk);
        #1;
        chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        chk("gnt", 64'(gnt), 64'(m_gnt));
        if (m_valid) begin
            chk("cdb_data", 64'(cdb_data), 64'(m_data));
            chk("cdb_addr", 64'(cdb_addr), 64'(m_addr));
            chk("cdb_rbidx", 64'(cdb_rbidx), 64'(m_rb));
            chk("cdb_fu", 64'(cdb_fu), 64'(m_fu));
        end
`ifdef CDB_STATS_EN
        chk("stat_bcast", 64'(stat_bcast), 64'(m_nb));
        chk("stat_stall", 64'(stat_stall), 64'(m_ns));
`endif
        if (auto_drop) begin
            for (int i = 0; i < N; i++) if (m_gnt[i]) fu_req[i] = 1'b0;
        end
        flush = 1'b0;
        drive();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_data", 64'(cdb_data), 64'd0);
        chk("rst_addr", 64'(cdb_addr), 64'd0);
        chk("rst_rbidx", 64'(cdb_rbidx), 64'd0);
        chk("rst_fu", 64'(cdb_fu), 64'd0);
        m_valid = 1'b0;
        m_gnt   = '0;
        m_ptr   = N - 1;
        m_data  = '0;
        m_addr  = '0;
        m_rb    = '0;
        m_fu    = 0;
        m_nb    = 0;
        m_ns    = 0;
        for (int i = 0; i < N; i++) fu_req[i] = 1'b0;
        drive();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        nvec      = 0;
        nfail     = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        cdb_ready = 1'b1;
        auto_drop = 1'b1;
        for (int i = 0; i < N; i++) begin
            fu_req[i]  = 1'b0;
            fu_data[i] = 32'h1000_0000 + 32'(i);
            fu_addr[i] = 32'hA000_0000 + 32'(i);
            fu_rb[i]   = 4'(i);
        end
        drive();
        #2;
        do_reset();

        // Single requester: FU2 broadcast for exactly one cycle
        fu_req[2]  = 1'b1;
        fu_data[2] = 32'h0000_1234;
        fu_rb[2]   = 4'd5;
        step(1'b0, 1'b1);
        chk("single_data", 64'(cdb_data), 64'h1234);
        chk("single_rbidx", 64'(cdb_rbidx), 64'd5);
        chk("single_fu", 64'(cdb_fu), 64'd2);
        chk("single_gnt", 64'(gnt), 64'h04);
        step(1'b0, 1'b1);
        chk("single_after", 64'(cdb_valid), 64'd0);

        // Fairness: all eight held for 16 cycles
        do_reset();
        auto_drop = 1'b0;
        for (int i = 0; i < N; i++) begin
            fu_req[i] = 1'b1;
            cnt[i]    = 0;
        end
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 1'b1);
            chk("fair_seq", 64'(cdb_fu), 64'(k % N));
            cnt[cdb_fu]++;
        end
        for (int i = 0; i < N; i++) chk("fair_count", 64'(cnt[i]), 64'd2);
        for (int i = 0; i < N; i++) fu_req[i] = 1'b0;
        auto_drop = 1'b1;
        step(1'b0, 1'b1);

        // Back-pressure: FU1 held four cycles, then FU3
        do_reset();
        fu_req[1] = 1'b1;
        fu_req[3] = 1'b1;
        step(1'b0, 1'b1);
        chk("bp_first_fu", 64'(cdb_fu), 64'd1);
        chk("bp_first_gnt", 64'(gnt), 64'h02);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0);
            chk("bp_hold_fu", 64'(cdb_fu), 64'd1);
            chk("bp_hold_gnt", 64'(gnt), 64'd0);
            chk("bp_hold_valid", 64'(cdb_valid), 64'd1);
        end
        step(1'b0, 1'b1);
        chk("bp_next_fu", 64'(cdb_fu), 64'd3);
        chk("bp_next_gnt", 64'(gnt), 64'h08);
        step(1'b0, 1'b1);

        // Flush: FU4 squashed, pointer stays at 4 so FU5 wins next
        do_reset();
        fu_req[4] = 1'b1;
        fu_req[5] = 1'b1;
        step(1'b0, 1'b1);
        chk("fl_first_fu", 64'(cdb_fu), 64'd4);
        step(1'b1, 1'b1);
        chk("fl_valid", 64'(cdb_valid), 64'd0);
        chk("fl_gnt", 64'(gnt), 64'd0);
        step(1'b0, 1'b1);
        chk("fl_next_fu", 64'(cdb_fu), 64'd5);
        chk("fl_next_gnt", 64'(gnt), 64'h20);
        step(1'b0, 1'b1);

        // Reset in the middle of a broadcast
        fu_req[6] = 1'b1;
        step(1'b0, 1'b1);
        chk("mid_valid", 64'(cdb_valid), 64'd1);
        do_reset();
        fu_req[0] = 1'b1;
        step(1'b0, 1'b1);
        chk("post_rst_fu", 64'(cdb_fu), 64'd0);
        chk("post_rst_gnt", 64'(gnt), 64'h01);
        step(1'b0, 1'b1);

        // Randomized traffic with back-pressure and occasional flush
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!fu_req[i] && ($urandom_range(0, 3) == 0)) begin
                    fu_req[i]  = 1'b1;
                    fu_data[i] = $urandom;
                    fu_addr[i] = $urandom;
                    fu_rb[i]   = 4'($urandom_range(0, 15));
                end
            end
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
